// File: rtl/instr_prefetch_queue.sv
// ---------------------------------------------------------------------------
// instr_prefetch_queue
//
// Fetch front end ahead of the IF/ID register. It issues sequential word
// fetches to instruction memory (one request outstanding at most), buffers
// the returned words with their PCs in a small FIFO, and presents the head
// entry as {instr, pc, pc+4}. A redirect flushes the queue and restarts
// fetching at the new address.
//
// Parameters
//   DEPTH     queue entries, power of two, 2..16
//   RESET_PC  first fetch address after reset
//
// Ports
//   CLK, RST        clock (rising edge); asynchronous active-high reset
//   imem_req_*      fetch request: valid/ready handshake, word-aligned address
//   imem_rsp_*      fetch response: one word per accepted request
//   redirect_*      flush and restart fetch at redirect_pc (bits [1:0] dropped)
//   instr_ready     consumer takes the head entry this cycle
//   instr_valid     head entry present
//   instr_out       head instruction word
//   instr_pc        head PC
//   instr_pc_plus4  head PC + 4 (wraps modulo 2^32)
//
// Optional feature (macro PREFETCH_STATS_EN):
//   stat_flush_cnt   redirects that threw away a queued or in-flight word
//   stat_starve_cnt  cycles with instr_ready=1 and nothing to deliver
//   Both are 16-bit saturating counters, reset to 0.
// ---------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0] stat_flush_cnt,
    output logic [15:0] stat_starve_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Control state
    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic            r_req_valid;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    // Datapath storage (not reset; qualified by r_count / r_req_valid)
    logic [31:0]     r_req_pc;
    logic [31:0]     r_instr_mem [DEPTH];
    logic [31:0]     r_pc_mem    [DEPTH];

    logic            w_xfer;
    logic            w_push;
    logic            w_pop;
    state_t          w_state_nx;
    logic [31:0]     w_fetch_pc_nx;
    logic [CW-1:0]   w_count_nx;
    logic            w_req_valid_nx;
    logic            w_unused;

    // The low address bits of a redirect target are forced to zero.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    always_comb begin
        // r_req_valid is only ever set while in FETCH, so a transfer implies FETCH.
        w_xfer        = r_req_valid & imem_req_ready;
        w_push        = (r_state == S_WAIT) & imem_rsp_valid & ~redirect_valid;
        w_pop         = instr_valid & instr_ready & ~redirect_valid;
        w_state_nx    = r_state;
        w_fetch_pc_nx = r_fetch_pc;

        case (r_state)
            S_FETCH: begin
                if (w_xfer) begin
                    w_state_nx    = S_WAIT;
                    w_fetch_pc_nx = r_fetch_pc + 32'd4;
                end
            end
            S_WAIT:  if (imem_rsp_valid) w_state_nx = S_FETCH;
            S_DRAIN: if (imem_rsp_valid) w_state_nx = S_FETCH;
            default: w_state_nx = S_FETCH;
        endcase

        // After the normal transition, WAIT means "a request is still in flight
        // past this edge". A redirect turns that word stale, so it must be
        // drained. A response landing with the redirect has already retired the
        // only outstanding request, so fetch restarts straight away.
        if (redirect_valid) begin
            w_fetch_pc_nx = {redirect_pc[31:2], 2'b00};
            if (w_state_nx == S_WAIT) w_state_nx = S_DRAIN;
        end

        if (redirect_valid) begin
            w_count_nx = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nx = r_count + CW'(1);
                2'b01:   w_count_nx = r_count - CW'(1);
                default: w_count_nx = r_count;
            endcase
        end

        // Only FETCH has nothing outstanding, so count < DEPTH there already
        // reserves a slot for the response of the request about to be issued.
        w_req_valid_nx = (w_state_nx == S_FETCH) && (w_count_nx < CW'(DEPTH));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_FETCH;
            r_fetch_pc  <= RESET_PC;
            r_req_valid <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_fetch_pc  <= w_fetch_pc_nx;
            r_req_valid <= w_req_valid_nx;
            r_count     <= w_count_nx;
            if (redirect_valid) begin
                // Pushes are suppressed on a redirect, so aligning the read
                // pointer to the write pointer empties the queue.
                r_rptr <= r_wptr;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_xfer) r_req_pc <= r_fetch_pc;
        if (w_push) begin
            r_instr_mem[r_wptr] <= imem_rsp_data;
            r_pc_mem[r_wptr]    <= r_req_pc;
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_fetch_pc;

    // Head outputs read as zero whenever the queue is empty, which also keeps
    // them at zero straight out of reset without resetting the storage.
    assign instr_valid    = (r_count != '0);
    assign instr_out      = instr_valid ? r_instr_mem[r_rptr]       : 32'h0;
    assign instr_pc       = instr_valid ? r_pc_mem[r_rptr]          : 32'h0;
    assign instr_pc_plus4 = instr_valid ? r_pc_mem[r_rptr] + 32'd4  : 32'h0;

`ifdef PREFETCH_STATS_EN
    logic [15:0] r_flush_cnt;
    logic [15:0] r_starve_cnt;
    logic        w_flush_hit;
    logic        w_starve_hit;

    // A redirect loses work if the queue holds entries, a live request is in
    // flight, or a request is accepted on the same edge. A word already being
    // drained was counted by the redirect that made it stale.
    assign w_flush_hit  = redirect_valid & (instr_valid | (r_state == S_WAIT) | w_xfer);
    assign w_starve_hit = ~instr_valid & instr_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_flush_cnt  <= 16'h0;
            r_starve_cnt <= 16'h0;
        end else begin
            if (w_flush_hit && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
            if (w_starve_hit && (r_starve_cnt != 16'hFFFF))
                r_starve_cnt <= r_starve_cnt + 16'd1;
        end
    end

    assign stat_flush_cnt  = r_flush_cnt;
    assign stat_starve_cnt = r_starve_cnt;
`endif

endmodule
